// File: rtl/symbol_sequencer_pkg.sv
// Shared types, defaults and the round-length clamp used by the symbol sequencer.
package symbol_sequencer_pkg;

    localparam int SYM_W_DEF = 4;
    localparam int DEPTH_DEF = 8;
    localparam int LEN_W     = 5;
    localparam int SCORE_W   = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        SHOW  = 3'd2,
        GAP   = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } state_t;

    // A zero request still plays one symbol; anything beyond the buffer is cut to DEPTH.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [3:0] req, input int depth);
        logic [LEN_W-1:0] r;
        if (req == 4'd0)
            r = LEN_W'(1);
        else if (int'(req) > depth)
            r = LEN_W'(depth);
        else
            r = {1'b0, req};
        return r;
    endfunction

endpackage

// File: rtl/symbol_sequencer_if.sv
// Handshake bundle between the sequencer and the random source, display and keypad.
interface symbol_sequencer_if
    import symbol_sequencer_pkg::*;
#(
    parameter int SYM_W = SYM_W_DEF
) ();

    logic               start;
    logic [3:0]         seq_len;
    logic [SYM_W-1:0]   rand_num;
    logic               rand_en;
    logic               in_valid;
    logic [SYM_W-1:0]   in_sym;
    logic [SYM_W-1:0]   disp_sym;
    logic               disp_valid;
    logic               busy;
    logic               done;
    logic               pass;
    logic               fail;
    logic [SCORE_W-1:0] score;

    modport master (
        output start, seq_len, rand_num, in_valid, in_sym,
        input  rand_en, disp_sym, disp_valid, busy, done, pass, fail, score
    );

    modport slave (
        input  start, seq_len, rand_num, in_valid, in_sym,
        output rand_en, disp_sym, disp_valid, busy, done, pass, fail, score
    );

endinterface

// File: rtl/symbol_sequencer_buffer.sv
// Reset-free DEPTH x SYM_W register file holding the symbols of the current round.
module seq_buffer
    import symbol_sequencer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int SYM_W = SYM_W_DEF
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [SYM_W-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [SYM_W-1:0]         rdata
);

    logic [SYM_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/symbol_sequencer.sv
// Round controller: fills a buffer from the random source, plays it, then scores key entries.
//   state | meaning
//   IDLE  | waiting for the first start
//   FILL  | rand_en high, one capture per cycle
//   SHOW  | buf[idx] lit for SHOW_CYCLES
//   GAP   | display blank for GAP_CYCLES
//   CHECK | comparing key entries against buf[idx]
//   DONE  | result held until the next start
module symbol_sequencer
    import symbol_sequencer_pkg::*;
#(
    parameter int DEPTH       = DEPTH_DEF,
    parameter int SYM_W       = SYM_W_DEF,
    parameter int SHOW_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 5_000_000
) (
    input  logic              clk,
    input  logic              reset,
    symbol_sequencer_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int T_MAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int TW    = $clog2(T_MAX + 1);

    localparam logic [TW-1:0]      SHOW_LOAD = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0]      GAP_LOAD  = TW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE   = IDX_W'(1);
    localparam logic [LEN_W-1:0]   LEN_ONE   = LEN_W'(1);
    localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [LEN_W-1:0]   len, len_nxt;
    logic [TW-1:0]      timer, timer_nxt;
    logic [SCORE_W-1:0] score_q, score_nxt;
    logic               pass_q, pass_nxt;
    logic               fail_q, fail_nxt;
    logic               last;
    logic               advance;
    logic [SYM_W-1:0]   rd_data;

    seq_buffer #(
        .DEPTH (DEPTH),
        .SYM_W (SYM_W)
    ) u_buf (
        .clk   (clk),
        .we    (state == FILL),
        .waddr (idx),
        .wdata (bus.rand_num),
        .raddr (idx),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            len     <= '0;
            timer   <= '0;
            score_q <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            len     <= len_nxt;
            timer   <= timer_nxt;
            score_q <= score_nxt;
            pass_q  <= pass_nxt;
            fail_q  <= fail_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        len_nxt   = len;
        timer_nxt = timer;
        score_nxt = score_q;
        pass_nxt  = pass_q;
        fail_nxt  = fail_q;
        advance   = 1'b0;
        last      = (LEN_W'(idx) == (len - LEN_ONE));

        unique case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nxt = FILL;
                    len_nxt   = clamp_len(bus.seq_len, DEPTH);
                    idx_nxt   = '0;
                    score_nxt = '0;
                    pass_nxt  = 1'b0;
                    fail_nxt  = 1'b0;
                end
            end
            FILL: begin
                if (last) begin
                    idx_nxt   = '0;
                    state_nxt = SHOW;
                    timer_nxt = SHOW_LOAD;
                end else begin
                    idx_nxt = idx + IDX_ONE;
                end
            end
            SHOW: begin
                if (timer == '0) begin
                    if (GAP_CYCLES != 0) begin
                        state_nxt = GAP;
                        timer_nxt = GAP_LOAD;
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    timer_nxt = timer - TW'(1);
                end
            end
            GAP: begin
                if (timer == '0)
                    advance = 1'b1;
                else
                    timer_nxt = timer - TW'(1);
            end
            CHECK: begin
                if (bus.in_valid) begin
                    if (bus.in_sym == rd_data) begin
                        score_nxt = score_q + SCORE_ONE;
                        if (last) begin
                            idx_nxt   = '0;
                            state_nxt = DONE;
                            pass_nxt  = 1'b1;
                        end else begin
                            idx_nxt = idx + IDX_ONE;
                        end
                    end else begin
                        state_nxt = DONE;
                        fail_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // End of one symbol's display slot, whether or not a blank gap was used.
        if (advance) begin
            if (last) begin
                idx_nxt   = '0;
                state_nxt = CHECK;
            end else begin
                idx_nxt   = idx + IDX_ONE;
                state_nxt = SHOW;
                timer_nxt = SHOW_LOAD;
            end
        end
    end

    assign bus.rand_en    = (state == FILL);
    assign bus.disp_valid = (state == SHOW);
    assign bus.disp_sym   = (state == SHOW) ? rd_data : '0;
    assign bus.busy       = (state == FILL) || (state == SHOW) || (state == GAP) || (state == CHECK);
    assign bus.done       = (state == DONE);
    assign bus.pass       = pass_q;
    assign bus.fail       = fail_q;
    assign bus.score      = score_q;

endmodule

// File: tb/tb_symbol_sequencer.sv
// Scoreboard bench for symbol_sequencer with short show/gap timers.
module tb_symbol_sequencer;

    localparam int SHOW_C = 4;
    localparam int GAP_C  = 2;
    localparam int DEPTH  = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;

    symbol_sequencer_if #(.SYM_W(4)) bus ();

    symbol_sequencer #(
        .DEPTH       (DEPTH),
        .SYM_W       (4),
        .SHOW_CYCLES (SHOW_C),
        .GAP_CYCLES  (GAP_C)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int en_count, shown_count, show_run, gap_run;
    bit consumed = 0;
    bit mon_en = 0;
    bit prev_valid = 0;
    logic [3:0] exp_sym;
    logic [3:0] rand_q[$];
    logic [3:0] fill_q[$];
    logic [3:0] round_syms[$];
    logic [3:0] shown_log[$];

    function automatic logic [3:0] next_rand();
        if (rand_q.size() > 0)
            return rand_q.pop_front();
        return 4'($urandom_range(15, 0));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a fresh random value once the previous one has been captured.
    initial forever begin
        @(posedge clk);
        #1;
        if (consumed)
            bus.rand_num = next_rand();
    end

    // Scoreboard: what the bench drove while rand_en was high must come back on the display.
    always @(negedge clk) begin
        if (bus.rand_en === 1'b1) begin
            fill_q.push_back(bus.rand_num);
            round_syms.push_back(bus.rand_num);
            en_count++;
            consumed = 1;
        end else begin
            consumed = 0;
        end
        if (mon_en) begin
            if (bus.disp_valid === 1'b1) begin
                if (!prev_valid) begin
                    if (shown_count > 0) begin
                        total++;
                        if (gap_run !== GAP_C) begin
                            bad++;
                            $display("FAIL gap_len: got %0d expected %0d", gap_run, GAP_C);
                        end
                    end
                    if (fill_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_symbol: got %0d expected none", bus.disp_sym);
                        exp_sym = 4'hx;
                    end else begin
                        exp_sym = fill_q.pop_front();
                    end
                    shown_log.push_back(bus.disp_sym);
                    shown_count++;
                    show_run = 0;
                end
                show_run++;
                total++;
                if (bus.disp_sym !== exp_sym) begin
                    bad++;
                    $display("FAIL disp_sym: got %0d expected %0d", bus.disp_sym, exp_sym);
                end
            end else begin
                if (prev_valid) begin
                    total++;
                    if (show_run !== SHOW_C) begin
                        bad++;
                        $display("FAIL show_len: got %0d expected %0d", show_run, SHOW_C);
                    end
                    gap_run = 0;
                end
                gap_run++;
                total++;
                if (bus.disp_sym !== 4'd0) begin
                    bad++;
                    $display("FAIL blank_sym: got %0d expected 0", bus.disp_sym);
                end
            end
            prev_valid = (bus.disp_valid === 1'b1);
        end
    end

    task automatic start_round(input logic [3:0] req, input bit with_key);
        fill_q.delete();
        round_syms.delete();
        shown_log.delete();
        en_count = 0;
        shown_count = 0;
        show_run = 0;
        gap_run = 0;
        prev_valid = 0;
        mon_en = 1;
        bus.seq_len = req;
        bus.start = 1'b1;
        if (with_key) begin
            bus.in_valid = 1'b1;
            bus.in_sym = 4'd4;
        end
        bus.rand_num = next_rand();
        tick();
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        total++;
        if (bus.busy !== 1'b1 || bus.rand_en !== 1'b1 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL start_accept: got busy=%0b rand_en=%0b done=%0b expected 1 1 0",
                     bus.busy, bus.rand_en, bus.done);
        end
        total++;
        if (bus.score !== 5'd0 || bus.pass !== 1'b0 || bus.fail !== 1'b0) begin
            bad++;
            $display("FAIL start_clear: got score=%0d pass=%0b fail=%0b expected 0 0 0",
                     bus.score, bus.pass, bus.fail);
        end
    endtask

    task automatic wait_check(input int exp_len);
        int n = 0;
        while (!(shown_count >= exp_len && bus.disp_valid === 1'b0) && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) begin
            total++;
            bad++;
            $display("FAIL play_timeout: got %0d symbols expected %0d", shown_count, exp_len);
        end
        repeat (GAP_C + 1) tick();
        total++;
        if (en_count !== exp_len) begin
            bad++;
            $display("FAIL rand_en_cycles: got %0d expected %0d", en_count, exp_len);
        end
        total++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL in_check: got busy=%0b done=%0b expected 1 0", bus.busy, bus.done);
        end
    endtask

    task automatic send_key(input logic [3:0] s);
        bus.in_valid = 1'b1;
        bus.in_sym = s;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_result(input string tag, input bit d, input bit p, input bit f,
                                 input int sc);
        total++;
        if (bus.done !== d || bus.pass !== p || bus.fail !== f || bus.score !== 5'(sc)) begin
            bad++;
            $display("FAIL %s: got done=%0b pass=%0b fail=%0b score=%0d expected %0b %0b %0b %0d",
                     tag, bus.done, bus.pass, bus.fail, bus.score, d, p, f, sc);
        end
    endtask

    task automatic test_reset();
        bus.start = 0;
        bus.seq_len = 0;
        bus.in_valid = 0;
        bus.in_sym = 0;
        bus.rand_num = 0;
        reset = 1'b1;
        repeat (3) tick();
        total++;
        if (bus.busy !== 1'b0 || bus.rand_en !== 1'b0 || bus.disp_valid !== 1'b0 ||
            bus.disp_sym !== 4'd0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%0b rand_en=%0b disp_valid=%0b disp_sym=%0d expected 0",
                     bus.busy, bus.rand_en, bus.disp_valid, bus.disp_sym);
        end
        expect_result("reset_result", 0, 0, 0, 0);
        reset = 1'b0;
        tick();

        rand_q = '{4'd5, 4'd9};
        start_round(4'd2, 0);
        for (int n = 0; n < 50 && bus.disp_valid !== 1'b1; n++) tick();
        total++;
        if (bus.disp_valid !== 1'b1) begin
            bad++;
            $display("FAIL reach_show: got disp_valid=%0b expected 1", bus.disp_valid);
        end
        mon_en = 0;
        #2 reset = 1'b1;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.disp_valid !== 1'b0 || bus.done !== 1'b0 ||
            bus.rand_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_midshow: got busy=%0b disp_valid=%0b done=%0b rand_en=%0b expected 0",
                     bus.busy, bus.disp_valid, bus.done, bus.rand_en);
        end
        expect_result("reset_midshow_result", 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        tick();
        rand_q = '{4'd12};
        start_round(4'd1, 0);
        wait_check(1);
        send_key(4'd12);
        expect_result("after_reset_round", 1, 1, 0, 1);
    endtask

    task automatic test_fill_show();
        logic [3:0] tab [3] = '{4'd3, 4'd7, 4'd1};
        rand_q = '{4'd3, 4'd7, 4'd1};
        start_round(4'd3, 0);
        wait_check(3);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= shown_log.size()) begin
                bad++;
                $display("FAIL shown_sym%0d: got none expected %0d", i, tab[i]);
            end else if (shown_log[i] !== tab[i]) begin
                bad++;
                $display("FAIL shown_sym%0d: got %0d expected %0d", i, shown_log[i], tab[i]);
            end
        end
    endtask

    task automatic test_pass();
        send_key(4'd3);
        send_key(4'd7);
        expect_result("pass_partial", 0, 0, 0, 2);
        send_key(4'd1);
        expect_result("pass_final", 1, 1, 0, 3);
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL pass_busy: got %0b expected 0", bus.busy);
        end
    endtask

    task automatic test_fail();
        rand_q = '{4'd3, 4'd7, 4'd1};
        start_round(4'd3, 0);
        wait_check(3);
        send_key(4'd3);
        expect_result("fail_first", 0, 0, 0, 1);
        send_key(4'd5);
        expect_result("fail_mismatch", 1, 0, 1, 1);
        send_key(4'd1);
        tick();
        expect_result("fail_hold", 1, 0, 1, 1);
    endtask

    task automatic test_clamp();
        start_round(4'd0, 0);
        wait_check(1);
        send_key(round_syms.size() > 0 ? round_syms[0] : 4'd0);
        expect_result("clamp_zero", 1, 1, 0, 1);

        start_round(4'd12, 0);
        wait_check(DEPTH);
        for (int i = 0; i < DEPTH; i++)
            send_key(i < round_syms.size() ? round_syms[i] : 4'd0);
        expect_result("clamp_depth", 1, 1, 0, DEPTH);
        total++;
        if (shown_count !== DEPTH) begin
            bad++;
            $display("FAIL clamp_shown: got %0d expected %0d", shown_count, DEPTH);
        end
    endtask

    task automatic test_back_to_back();
        rand_q = '{4'd4, 4'd9};
        start_round(4'd2, 0);
        wait_check(2);
        bus.seq_len = 4'd5;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++;
        if (bus.busy !== 1'b1 || bus.rand_en !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL start_in_check: got busy=%0b rand_en=%0b done=%0b expected 1 0 0",
                     bus.busy, bus.rand_en, bus.done);
        end
        send_key(4'd4);
        send_key(4'd9);
        expect_result("restart_first", 1, 1, 0, 2);

        rand_q = '{4'd6, 4'd2};
        start_round(4'd2, 1);
        wait_check(2);
        send_key(4'd6);
        send_key(4'd2);
        expect_result("restart_second", 1, 1, 0, 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill_show();
        test_pass();
        test_fail();
        test_clamp();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
